// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC datapath and its fixed-to-float back end.
package cordic_pkg;

  localparam int FIXED_W  = 22;
  localparam int FRAC_W   = 20;
  localparam int FLOAT_W  = 32;
  localparam int EXP_BIAS = 127;

  typedef logic signed [FIXED_W-1:0] fixed_t;
  typedef logic [FLOAT_W-1:0]        float_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } conv_state_t;

endpackage

// File: rtl/fixed_to_float_seq.sv
// Q2.20 fixed-point to IEEE-754 single converter. Normalises with one left shift
// per cycle so no priority encoder or barrel shifter sits on the path.
module fixed_to_float_seq
  import cordic_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   in_valid,
  output logic   in_ready,
  input  fixed_t fixed_in,
  output logic   out_valid,
  input  logic   out_ready,
  output float_t float_out,
  output logic   busy
);

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high; the producer holds its data stable until that edge.

  conv_state_t          state;
  logic                 sign;
  logic [FIXED_W-1:0]   mag;
  // Exponent only spans 107..128 during normalisation, so 8 bits hold it.
  logic [7:0]           exp;
  logic [FIXED_W-1:0]   abs_in;

  // -2.0 negates to itself, which is exactly the magnitude 2.0 we want.
  assign abs_in    = fixed_in[FIXED_W-1] ? (~fixed_in + 1'b1) : fixed_in;

  assign in_ready  = (state == IDLE) && !reset;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      float_out <= '0;
      sign      <= 1'b0;
      mag       <= '0;
      exp       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign <= fixed_in[FIXED_W-1];
            mag  <= abs_in;
            exp  <= 8'(EXP_BIAS + 1);
            if (fixed_in == '0) begin
              float_out <= '0;
              state     <= DONE;
            end else begin
              state <= CONV;
            end
          end
        end
        CONV: begin
          if (mag[FIXED_W-1]) begin
            float_out <= {sign, exp, mag[FIXED_W-2:0], 2'b00};
            state     <= DONE;
          end else begin
            mag <= mag << 1;
            exp <= exp - 8'd1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
